// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the fetch path
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - 2-entry fetch buffer with push/pop/flush and occupancy
module if_fifo
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  if_entry_t  push_data,
    input  logic       pop,
    input  logic       flush,
    output if_entry_t  head,
    output logic       empty,
    output logic [1:0] occupancy
);

    if_entry_t  mem_q [2];
    if_entry_t  mem_d [2];
    logic       rd_ptr_q;
    logic       rd_ptr_d;
    logic       wr_ptr_q;
    logic       wr_ptr_d;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_push;
    logic       do_pop;

    always_comb begin
        do_push  = push && (count_q != 2'd2);
        do_pop   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // Flush wins over any same-cycle push or pop.
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign empty     = (count_q == 2'd0);
    assign occupancy = count_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage; IF_STAGE_PERF_CNT_EN adds fetch_count
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            im_req,
    output logic [XLEN-1:0] im_addr,
    input  logic            im_rvalid,
    input  logic [XLEN-1:0] im_rdata,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instruction
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count
`endif
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic            req;
    logic            push;
    logic            pop;
    if_entry_t       push_data;
    if_entry_t       head;
    logic            empty;
    logic [1:0]      occupancy;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req        = 1'b0;
        push       = 1'b0;
        case (state_q)
            REQ: begin
                if (!redirect && (occupancy < 2'd2)) begin
                    req     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A redirect orphans the outstanding read; DROP swallows it if still in flight.
                if (redirect) begin
                    state_d = im_rvalid ? REQ : DROP;
                end else if (im_rvalid) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = REQ;
                end
            end
            DROP: begin
                if (im_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign push_data = '{pc: fetch_pc_q, instr: im_rdata};

    if_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .empty     (empty),
        .occupancy (occupancy)
    );

    // Reset parks the FSM in REQ, so the strobe must be masked while rst is low.
    assign im_req        = req & rst;
    assign im_addr       = fetch_pc_q;
    assign o_valid       = !empty && !redirect;
    assign pop           = o_valid && !stall;
    assign o_pc          = o_valid ? head.pc : '0;
    assign o_instruction = o_valid ? head.instr : '0;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + (pop ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;

    logic        stall_w;
    logic        redirect_w;
    logic [31:0] redirect_pc_w;
    logic        im_req_w;
    logic [31:0] im_addr_w;
    logic        im_rvalid_w;
    logic [31:0] im_rdata_w;
    logic        o_valid_w;
    logic [31:0] o_pc_w;
    logic [31:0] o_instr_w;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] fetch_count_w;
`endif

    logic        mem_auto;
    int          mem_lat;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        man_rvalid;
    logic [31:0] man_rdata;

    assign im_rvalid = mem_rvalid | man_rvalid;
    assign im_rdata  = man_rvalid ? man_rdata : mem_rdata;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc = 32'h0;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .im_req        (im_req),
        .im_addr       (im_addr),
        .im_rvalid     (im_rvalid),
        .im_rdata      (im_rdata),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_instruction (o_instruction)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall_w),
        .redirect      (redirect_w),
        .redirect_pc   (redirect_pc_w),
        .im_req        (im_req_w),
        .im_addr       (im_addr_w),
        .im_rvalid     (im_rvalid_w),
        .im_rdata      (im_rdata_w),
        .o_valid       (o_valid_w),
        .o_pc          (o_pc_w),
        .o_instruction (o_instr_w)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count_w)
`endif
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: one read at a time, response mem_lat cycles after the strobe.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mem_addr   = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_auto && im_req && rst) begin
                mem_addr = im_addr;
                @(posedge clk);
                repeat (mem_lat - 1) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = mdata(mem_addr);
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        man_rvalid = 1'b0; man_rdata = 32'h0; mem_auto = 1'b1; mem_lat = 1;
        stall_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = 32'h0;
        im_rvalid_w = 1'b0; im_rdata_w = 32'h0;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL reset_im_req: got %b want 0", im_req); end
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_o_pc: got %h want 0", o_pc); end
        n_cmp++; if (o_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_o_instr: got %h want 0", o_instruction); end
        n_cmp++; if (im_req_w !== 1'b0) begin n_fail++; $display("FAIL reset_im_req_w: got %b want 0", im_req_w); end
`ifdef IF_STAGE_PERF_CNT_EN
        n_cmp++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_count: got %h want 0", fetch_count); end
`endif
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (im_req !== 1'b1) begin n_fail++; $display("FAIL first_im_req: got %b want 1", im_req); end
        n_cmp++; if (im_addr !== 32'h0) begin n_fail++; $display("FAIL first_im_addr: got %h want 0", im_addr); end
        n_cmp++; if (im_req_w !== 1'b1) begin n_fail++; $display("FAIL first_im_req_w: got %b want 1", im_req_w); end
        n_cmp++; if (im_addr_w !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL first_im_addr_w: got %h want fffffff8", im_addr_w); end
    endtask

    task automatic test_stream();
        int got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            @(negedge clk);
            if (o_valid && !stall) begin
                n_cmp++; if (o_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc: got %h want %h", o_pc, exp_pc); end
                n_cmp++; if (o_instruction !== mdata(exp_pc)) begin n_fail++; $display("FAIL stream_instr: got %h want %h", o_instruction, mdata(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
        end
        n_cmp++; if (got != 6) begin n_fail++; $display("FAIL stream_count: got %0d want 6", got); end
    endtask

    task automatic test_stall();
        int got = 0;
        tick();
        stall = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_valid) begin
                n_cmp++; if (o_pc !== exp_pc) begin n_fail++; $display("FAIL stall_hold_pc: got %h want %h", o_pc, exp_pc); end
            end
        end
        n_cmp++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL stall_im_req: got %b want 0", im_req); end
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_o_valid: got %b want 1", o_valid); end
        tick();
        stall = 1'b0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (o_valid) begin
                n_cmp++; if (o_pc !== exp_pc) begin n_fail++; $display("FAIL stall_release_pc: got %h want %h", o_pc, exp_pc); end
                n_cmp++; if (o_instruction !== mdata(exp_pc)) begin n_fail++; $display("FAIL stall_release_instr: got %h want %h", o_instruction, mdata(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
        end
        n_cmp++; if (got != 4) begin n_fail++; $display("FAIL stall_release_count: got %0d want 4", got); end
    endtask

    task automatic test_redirect_wait();
        logic seen = 1'b0;
        mem_lat = 3;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = im_req;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rdw_req_timeout: got 0 want 1"); end
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_o_valid_redirect: got %b want 0", o_valid); end
        n_cmp++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL rdw_im_req_redirect: got %b want 0", im_req); end
        tick();
        redirect = 1'b0;
        mem_lat = 1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (im_req) begin
                seen = 1'b1;
                n_cmp++; if (im_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rdw_addr: got %h want 00000100", im_addr); end
            end else begin
                n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_o_valid_drop: got %b want 0", o_valid); end
            end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rdw_refetch_timeout: got 0 want 1"); end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1'b1;
                n_cmp++; if (o_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL rdw_first_pc: got %h want 00000100", o_pc); end
                n_cmp++; if (o_instruction !== mdata(32'h100)) begin n_fail++; $display("FAIL rdw_first_instr: got %h want %h", o_instruction, mdata(32'h100)); end
            end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rdw_deliver_timeout: got 0 want 1"); end
    endtask

    task automatic test_redirect_rvalid();
        logic seen = 1'b0;
        mem_lat = 2;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = im_req;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rdr_req_timeout: got 0 want 1"); end
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_o_valid: got %b want 0", o_valid); end
        tick();
        redirect = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        n_cmp++; if (im_req !== 1'b1) begin n_fail++; $display("FAIL rdr_im_req: got %b want 1", im_req); end
        n_cmp++; if (im_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL rdr_im_addr: got %h want 00000200", im_addr); end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1'b1;
                n_cmp++; if (o_pc !== 32'h0000_0200) begin n_fail++; $display("FAIL rdr_first_pc: got %h want 00000200", o_pc); end
                n_cmp++; if (o_instruction !== mdata(32'h200)) begin n_fail++; $display("FAIL rdr_first_instr: got %h want %h", o_instruction, mdata(32'h200)); end
            end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rdr_deliver_timeout: got 0 want 1"); end
    endtask

    task automatic test_wrap();
        tick();
        im_rvalid_w = 1'b1;
        im_rdata_w  = mdata(32'hFFFF_FFF8);
        tick();
        im_rvalid_w = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_valid_w !== 1'b1) begin n_fail++; $display("FAIL wrap_o_valid: got %b want 1", o_valid_w); end
        n_cmp++; if (o_pc_w !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_pc0: got %h want fffffff8", o_pc_w); end
        n_cmp++; if (o_instr_w !== mdata(32'hFFFF_FFF8)) begin n_fail++; $display("FAIL wrap_instr0: got %h want %h", o_instr_w, mdata(32'hFFFF_FFF8)); end
        n_cmp++; if (im_req_w !== 1'b1) begin n_fail++; $display("FAIL wrap_req1: got %b want 1", im_req_w); end
        n_cmp++; if (im_addr_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr1: got %h want fffffffc", im_addr_w); end
        tick();
        im_rvalid_w = 1'b1;
        im_rdata_w  = mdata(32'hFFFF_FFFC);
        tick();
        im_rvalid_w = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_pc_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc1: got %h want fffffffc", o_pc_w); end
        n_cmp++; if (im_req_w !== 1'b1) begin n_fail++; $display("FAIL wrap_req2: got %b want 1", im_req_w); end
        n_cmp++; if (im_addr_w !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr2: got %h want 00000000", im_addr_w); end
    endtask

    task automatic test_reset_wait();
        tick();
        stall = 1'b1;
        repeat (6) tick();
        mem_auto = 1'b0;
        tick();
        stall = 1'b0;
        tick();
        stall = 1'b1;
        @(negedge clk);
        n_cmp++; if (im_req !== 1'b1) begin n_fail++; $display("FAIL rw_pre_req: got %b want 1", im_req); end
        tick();
        @(negedge clk);
        n_cmp++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL rw_wait_req: got %b want 0", im_req); end
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rw_pre_o_valid: got %b want 1", o_valid); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL rw_async_im_req: got %b want 0", im_req); end
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rw_async_o_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL rw_async_o_pc: got %h want 0", o_pc); end
        n_cmp++; if (o_instruction !== 32'h0) begin n_fail++; $display("FAIL rw_async_o_instr: got %h want 0", o_instruction); end
        tick();
        rst = 1'b1;
        stall = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        n_cmp++; if (im_req !== 1'b1) begin n_fail++; $display("FAIL rw_restart_req: got %b want 1", im_req); end
        n_cmp++; if (im_addr !== 32'h0) begin n_fail++; $display("FAIL rw_restart_addr: got %h want 0", im_addr); end
        tick();
        man_rdata = 32'h600D_F00D;
        tick();
        man_rvalid = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rw_o_valid: got %b want 1", o_valid); end
        n_cmp++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL rw_o_pc: got %h want 0", o_pc); end
        n_cmp++; if (o_instruction !== 32'h600D_F00D) begin n_fail++; $display("FAIL rw_o_instr: got %h want 600df00d", o_instruction); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-004 stall  input  1  downstream IF/ID register not accepting this cycle.
REQ-005 redirect  input  1  branch/jump taken; refetch from redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] ignored, forced to 0.
REQ-007 im_req  output  1  one-cycle instruction-memory read strobe.
REQ-008 im_addr  output  32  word-aligned read address, valid while im_req=1.
REQ-009 im_rvalid  input  1  read data valid; at least 1 cycle after im_req.
REQ-010 im_rdata  input  32  instruction word, valid with im_rvalid.
REQ-011 o_valid  output  1  o_pc/o_instruction hold a live instruction.
REQ-012 o_pc  output  32  PC of presented instruction.
REQ-013 o_instruction  output  32  presented instruction word.

Function
REQ-014 FSM states SHALL be REQ, WAIT, DROP; at most one memory read outstanding.
REQ-015 REQ: if buffer occupancy < 2 and no redirect, assert im_req with im_addr=fetch_pc, go WAIT; else stay REQ, im_req=0.
REQ-016 WAIT: on im_rvalid, push {fetch_pc, im_rdata} into buffer, fetch_pc += 4, go REQ.
REQ-017 fetch_pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-018 2-entry FIFO buffer; o_valid = buffer non-empty and redirect=0; o_pc/o_instruction = head entry.
REQ-019 Pop SHALL occur when o_valid=1 and stall=0; push and pop in the same cycle allowed, occupancy unchanged.
REQ-020 Overflow SHALL be impossible: request only when occupancy < 2; a push never targets a full buffer.
REQ-021 Redirect SHALL flush the buffer, load fetch_pc = {redirect_pc[31:2],2'b00} next edge; redirect has priority over stall and push.
REQ-022 Redirect in WAIT without im_rvalid -> DROP; with im_rvalid same cycle -> data discarded, go REQ.
REQ-023 DROP: discard next im_rvalid, then go REQ; redirect in DROP updates fetch_pc, stays DROP unless im_rvalid same cycle (then REQ).
REQ-024 im_rvalid in REQ state SHALL be ignored (no state or buffer change).
REQ-025 With o_valid=0, o_pc/o_instruction SHALL read 32'h0.

Reset
REQ-026 rst=0 SHALL asynchronously set: state REQ, fetch_pc=RESET_PC, buffer empty, im_req=0, o_valid=0, o_pc=0, o_instruction=0.
REQ-027 Reset mid-WAIT SHALL abandon the outstanding read; a late im_rvalid after release is ignored per REQ-024.
REQ-028 First im_req SHALL occur in the first cycle after rst deasserts.

Configuration
REQ-029 Macro IF_STAGE_PERF_CNT_EN defined: extra output fetch_count[31:0], counts pops (delivered instructions), wraps at 2^32, reset to 0.
REQ-030 Macro undefined: no fetch_count port, no counter logic; all other behaviour identical.

Structure
REQ-031 Shared package cpu_pkg SHALL hold XLEN=32, default RESET_PC, fetch-state enum, and buffer entry type {pc, instr}.
REQ-032 Sub-module if_fifo (2-entry, push/pop/flush, occupancy out) SHALL implement the buffer; FSM and PC live in if_stage.

Verification
REQ-033 Reset release, memory 1-cycle latency, stall=0 -> im_addr 0,4,8...; o_pc 0,4,8 with matching instructions, no gaps after first.
REQ-034 stall=1 held 5 cycles -> buffer fills to 2, im_req stops, o_pc constant; release -> in-order delivery, none lost or duplicated.
REQ-035 redirect to 32'h0000_0103 while WAIT -> next response dropped, next im_addr 32'h0000_0100, o_valid=0 until its data arrives.
REQ-036 redirect coincident with im_rvalid -> data discarded, im_req to new address next cycle, DROP not entered.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst pulsed low during WAIT -> outputs zero immediately; stray im_rvalid after release ignored; fetch restarts at RESET_PC.
